// File: rtl/nn_pkg.sv
// Shared types and helpers for the neuron read-address sequencer.
// Build option AG_BIAS_EN appends one bias step to every neuron.
package nn_pkg;

    typedef enum logic [1:0] {StIdle, StPrime, StRun, StDone} ag_state_t;

    localparam int unsigned AG_ADDR_W = 8;

    function automatic int unsigned steps_per_neuron(input int unsigned n_inputs);
`ifdef AG_BIAS_EN
        return n_inputs + 1;
`else
        return n_inputs;
`endif
    endfunction

endpackage

// File: rtl/address_generator_if.sv
// Control strobes in, memory addresses and ALU operand qualifiers out.
// Build option AG_BIAS_EN adds the acc_bias qualifier.
interface address_generator_if
    import nn_pkg::*;
#(
    parameter int unsigned ADDR_W = AG_ADDR_W
) ();

    logic              ag_rst;
    logic              ag_read;
    logic [ADDR_W-1:0] in_addr;
    logic [ADDR_W-1:0] w_addr;
    logic              rd_en;
    logic [ADDR_W-1:0] neuron_idx;
    logic              acc_valid;
    logic              acc_last;
    logic              done;
`ifdef AG_BIAS_EN
    logic              acc_bias;
`endif

    // master = ControlUnit/ALU side, slave = the address generator
    modport master (
        output ag_rst, output ag_read,
        input in_addr, input w_addr, input rd_en, input neuron_idx,
        input acc_valid, input acc_last, input done
`ifdef AG_BIAS_EN
        , input acc_bias
`endif
    );

    modport slave (
        input ag_rst, input ag_read,
        output in_addr, output w_addr, output rd_en, output neuron_idx,
        output acc_valid, output acc_last, output done
`ifdef AG_BIAS_EN
        , output acc_bias
`endif
    );

endinterface

// File: rtl/ag_delay_line.sv
// Fixed-depth shift register aligning operand qualifiers to memory read latency.
// Synchronous flush drops everything in flight.
module ag_delay_line #(
    parameter int unsigned Depth = 1,
    parameter int unsigned Width = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic [Width-1:0] data_i,
    output logic [Width-1:0] data_o
);

    logic [Width-1:0] stage_q [Depth];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) stage_q[i] <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < Depth; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= data_i;
            for (int i = 1; i < Depth; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign data_o = stage_q[Depth-1];

endmodule

// File: rtl/address_generator.sv
// Walks every (neuron, input) pair issuing input/weight read addresses, with latency-aligned
// valid/last for the accumulator. Build option AG_BIAS_EN adds a per-neuron bias step.
module address_generator
    import nn_pkg::*;
#(
    parameter int unsigned N_INPUTS  = 3,
    parameter int unsigned N_NEURONS = 2,
    parameter int unsigned ADDR_W    = AG_ADDR_W,
    parameter int unsigned MEM_LAT   = 1
) (
    input logic                clk,
    input logic                reset,
    address_generator_if.slave bus
);

    localparam int unsigned STEPS = steps_per_neuron(N_INPUTS);
    localparam logic [ADDR_W-1:0] LAST_STEP   = ADDR_W'(STEPS - 1);
    localparam logic [ADDR_W-1:0] LAST_NEURON = ADDR_W'(N_NEURONS - 1);
`ifdef AG_BIAS_EN
    localparam int unsigned DL_W = 3;
`else
    localparam int unsigned DL_W = 2;
`endif

    if (N_INPUTS == 0 || N_NEURONS == 0 || MEM_LAT == 0 ||
        64'(N_NEURONS) * 64'(STEPS) > (64'd1 << ADDR_W)) begin : g_param_err
        $error("address_generator: illegal parameters or ADDR_W too narrow");
    end

    ag_state_t         state_q, state_d;
    logic [ADDR_W-1:0] in_idx_q, in_idx_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] neuron_q, neuron_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [ADDR_W-1:0] in_addr_q, in_addr_d;
    logic              rd_en_q, rd_en_d;
    logic              done_q, done_d;
    logic              issue, step_last, flush;
    logic [DL_W-1:0]   dl_in, dl_out;

    always_comb begin
        state_d   = state_q;
        in_idx_d  = in_idx_q;
        base_d    = base_q;
        neuron_d  = neuron_q;
        w_addr_d  = w_addr_q;
        rd_en_d   = 1'b0;
        done_d    = 1'b0;
        flush     = 1'b0;
        issue     = (state_q == StRun);
        step_last = issue && (in_idx_q == LAST_STEP);

        if (bus.ag_rst) begin
            state_d  = StIdle;
            in_idx_d = '0;
            base_d   = '0;
            neuron_d = '0;
            w_addr_d = '0;
            flush    = 1'b1;
        end else begin
            unique case (state_q)
                StIdle, StPrime: begin
                    state_d = bus.ag_read ? StPrime : StRun;
                    rd_en_d = 1'b1;
                end
                StRun: begin
                    if (bus.ag_read) begin
                        // Restart the current neuron; its in-flight operands are stale.
                        state_d  = StPrime;
                        in_idx_d = '0;
                        w_addr_d = base_q;
                        rd_en_d  = 1'b1;
                        flush    = 1'b1;
                    end else if (in_idx_q != LAST_STEP) begin
                        in_idx_d = in_idx_q + ADDR_W'(1);
                        w_addr_d = w_addr_q + ADDR_W'(1);
                        rd_en_d  = 1'b1;
                    end else if (neuron_q == LAST_NEURON) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        in_idx_d = '0;
                        base_d   = base_q + ADDR_W'(STEPS);
                        neuron_d = neuron_q + ADDR_W'(1);
                        w_addr_d = w_addr_q + ADDR_W'(1);
                        rd_en_d  = 1'b1;
                    end
                end
                StDone: done_d = 1'b1;
                default: state_d = StIdle;
            endcase
        end

`ifdef AG_BIAS_EN
        in_addr_d = (in_idx_d == LAST_STEP) ? '0 : in_idx_d;
`else
        in_addr_d = in_idx_d;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            in_idx_q  <= '0;
            base_q    <= '0;
            neuron_q  <= '0;
            w_addr_q  <= '0;
            in_addr_q <= '0;
            rd_en_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_idx_q  <= in_idx_d;
            base_q    <= base_d;
            neuron_q  <= neuron_d;
            w_addr_q  <= w_addr_d;
            in_addr_q <= in_addr_d;
            rd_en_q   <= rd_en_d;
            done_q    <= done_d;
        end
    end

`ifdef AG_BIAS_EN
    assign dl_in = {issue, step_last, step_last};
    assign bus.acc_bias = dl_out[0];
`else
    assign dl_in = {issue, step_last};
`endif

    ag_delay_line #(
        .Depth (MEM_LAT),
        .Width (DL_W)
    ) u_delay (
        .clk_i   (clk),
        .rst_ni  (reset),
        .flush_i (flush),
        .data_i  (dl_in),
        .data_o  (dl_out)
    );

    assign bus.in_addr    = in_addr_q;
    assign bus.w_addr     = w_addr_q;
    assign bus.rd_en      = rd_en_q;
    assign bus.neuron_idx = neuron_q;
    assign bus.done       = done_q;
    assign bus.acc_valid  = dl_out[DL_W-1];
    assign bus.acc_last   = dl_out[DL_W-2];

endmodule

// File: tb/tb_address_generator.sv
// Drives two generators (read latency 1 and 3) with the same strobes and compares them
// cycle by cycle against a step-index reference model.
module tb_address_generator;

    localparam int unsigned ADDR_W = 8;
`ifdef AG_BIAS_EN
    localparam int unsigned N_IN = 2;
    localparam bit          BIAS = 1'b1;
`else
    localparam int unsigned N_IN = 3;
    localparam bit          BIAS = 1'b0;
`endif
    localparam int unsigned N_NEU = 2;
    localparam int unsigned STEPS = BIAS ? N_IN + 1 : N_IN;
    localparam int unsigned TOTAL = N_NEU * STEPS;
    localparam int unsigned LAT_A = 1;
    localparam int unsigned LAT_B = 3;

    localparam int M_IDLE = 0, M_PRIME = 1, M_RUN = 2, M_DONE = 3;

    typedef struct packed {
        logic v;
        logic l;
        logic b;
    } iss_t;

    logic clk = 1'b0;
    logic reset;
    logic ag_rst, ag_read;
    logic a_bias, b_bias;

    always #5 clk = ~clk;

    address_generator_if #(.ADDR_W(ADDR_W)) bus_a ();
    address_generator_if #(.ADDR_W(ADDR_W)) bus_b ();

    assign bus_a.ag_rst  = ag_rst;
    assign bus_a.ag_read = ag_read;
    assign bus_b.ag_rst  = ag_rst;
    assign bus_b.ag_read = ag_read;
`ifdef AG_BIAS_EN
    assign a_bias = bus_a.acc_bias;
    assign b_bias = bus_b.acc_bias;
`else
    assign a_bias = 1'b0;
    assign b_bias = 1'b0;
`endif

    address_generator #(
        .N_INPUTS (N_IN), .N_NEURONS (N_NEU), .ADDR_W (ADDR_W), .MEM_LAT (LAT_A)
    ) dut_a (
        .clk (clk), .reset (reset), .bus (bus_a)
    );

    address_generator #(
        .N_INPUTS (N_IN), .N_NEURONS (N_NEU), .ADDR_W (ADDR_W), .MEM_LAT (LAT_B)
    ) dut_b (
        .clk (clk), .reset (reset), .bus (bus_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a linear step index k over all (neuron, input) pairs.
    int   m_mode;
    int   m_k;
    iss_t pipe_a[$];
    iss_t pipe_b[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d required %0d (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic clear_pipes();
        pipe_a.delete();
        pipe_b.delete();
        for (int i = 0; i < LAT_A; i++) pipe_a.push_back('0);
        for (int i = 0; i < LAT_B; i++) pipe_b.push_back('0);
    endtask

    task automatic model_step(input logic rst, input logic rd);
        iss_t cur;
        bit   fl;
        cur = '0;
        fl  = 1'b0;
        if (m_mode == M_RUN) begin
            cur.v = 1'b1;
            cur.l = (m_k % STEPS == STEPS - 1);
            cur.b = BIAS && cur.l;
        end
        if (rst) begin
            m_mode = M_IDLE;
            m_k    = 0;
            fl     = 1'b1;
        end else begin
            case (m_mode)
                M_IDLE, M_PRIME: m_mode = rd ? M_PRIME : M_RUN;
                M_RUN: begin
                    if (rd) begin
                        m_mode = M_PRIME;
                        m_k    = (m_k / STEPS) * STEPS;
                        fl     = 1'b1;
                    end else if (m_k == TOTAL - 1) begin
                        m_mode = M_DONE;
                    end else begin
                        m_k++;
                    end
                end
                default: ;
            endcase
        end
        if (fl) begin
            clear_pipes();
        end else begin
            pipe_a.push_back(cur);
            void'(pipe_a.pop_front());
            pipe_b.push_back(cur);
            void'(pipe_b.pop_front());
        end
    endtask

    task automatic check_dut(input string nm, input logic rd, input logic dn, input logic v,
                             input logic l, input logic b, input logic [ADDR_W-1:0] ia,
                             input logic [ADDR_W-1:0] wa, input logic [ADDR_W-1:0] ni,
                             input iss_t e);
        int exp_ia;
        check_eq({nm, "_rd_en"}, rd, (m_mode == M_PRIME || m_mode == M_RUN));
        check_eq({nm, "_done"}, dn, (m_mode == M_DONE));
        check_eq({nm, "_acc_valid"}, v, e.v);
        check_eq({nm, "_acc_last"}, l, e.l);
`ifdef AG_BIAS_EN
        check_eq({nm, "_acc_bias"}, b, e.b);
`endif
        if (m_mode != M_DONE) begin
            exp_ia = (BIAS && (m_k % STEPS == STEPS - 1)) ? 0 : m_k % STEPS;
            check_eq({nm, "_w_addr"}, wa, m_k);
            check_eq({nm, "_in_addr"}, ia, exp_ia);
            check_eq({nm, "_neuron_idx"}, ni, m_k / STEPS);
        end
    endtask

    task automatic check_all();
        check_dut("a", bus_a.rd_en, bus_a.done, bus_a.acc_valid, bus_a.acc_last, a_bias,
                  bus_a.in_addr, bus_a.w_addr, bus_a.neuron_idx, pipe_a[0]);
        check_dut("b", bus_b.rd_en, bus_b.done, bus_b.acc_valid, bus_b.acc_last, b_bias,
                  bus_b.in_addr, bus_b.w_addr, bus_b.neuron_idx, pipe_b[0]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(ag_rst || !reset, ag_read);
        #1;
        check_all();
    endtask

    task automatic wait_w_addr(input string tag, input int target);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (bus_a.rd_en && bus_a.w_addr == ADDR_W'(target)) found = 1'b1;
        end
        check_eq(tag, found, 1);
    endtask

    task automatic pulse_ag_rst();
        ag_rst = 1'b1;
        tick();
        ag_rst = 1'b0;
    endtask

    initial begin
        int nv_a, nl_a, nv_b, nl_b;
        reset   = 1'b0;
        ag_rst  = 1'b0;
        ag_read = 1'b0;
        m_mode  = M_IDLE;
        m_k     = 0;
        clear_pipes();
        #2;
        check_all();
        tick();
        tick();

        // Prime twice, then run a full pass
        reset   = 1'b1;
        ag_read = 1'b1;
        nv_a = 0; nl_a = 0; nv_b = 0; nl_b = 0;
        for (int i = 0; i < TOTAL + 10; i++) begin
            if (i == 2) ag_read = 1'b0;
            tick();
            if (bus_a.acc_valid) nv_a++;
            if (bus_a.acc_valid && bus_a.acc_last) nl_a++;
            if (bus_b.acc_valid) nv_b++;
            if (bus_b.acc_valid && bus_b.acc_last) nl_b++;
        end
        check_eq("t1_valids_a", nv_a, TOTAL);
        check_eq("t1_lasts_a", nl_a, N_NEU);
        check_eq("t1_valids_b", nv_b, TOTAL);
        check_eq("t1_lasts_b", nl_b, N_NEU);

        // Restart request while reading neuron 1
        pulse_ag_rst();
        wait_w_addr("t2_reach_w4", 4);
        ag_read = 1'b1;
        tick();
        ag_read = 1'b0;
        for (int i = 0; i < TOTAL + 8; i++) tick();

        // Synchronous abort mid-run
        pulse_ag_rst();
        wait_w_addr("t3_reach_w2", 2);
        pulse_ag_rst();
        for (int i = 0; i < TOTAL + 8; i++) tick();

        // Asynchronous reset between edges
        pulse_ag_rst();
        wait_w_addr("t4_reach_w3", 3);
        #2;
        reset = 1'b0;
        #1;
        check_eq("t4_async_rd_en", bus_a.rd_en, 0);
        check_eq("t4_async_w_addr", bus_a.w_addr, 0);
        check_eq("t4_async_valid_a", bus_a.acc_valid, 0);
        check_eq("t4_async_valid_b", bus_b.acc_valid, 0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < TOTAL + 8; i++) tick();

        // Random strobes
        for (int i = 0; i < 400; i++) begin
            ag_rst  = ($urandom_range(0, 39) == 0);
            ag_read = ($urandom_range(0, 7) == 0);
            tick();
        end
        ag_rst  = 1'b0;
        ag_read = 1'b0;
        for (int i = 0; i < TOTAL + 8; i++) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
